// File: rtl/ret_stack.sv
// ret_stack: LIFO return-address stack for the processor control path.
//
// The control unit pushes the current PC on CALL and pops it on RET, so
// subroutines can nest up to DEPTH levels. Occupancy and full/empty status
// are reported, and misuse (a push into a full stack, a pop from an empty
// one) raises a sticky error flag instead of corrupting the stack.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; overrides every other input
//   push       store din as the new top of stack (level-sampled)
//   pop        remove the top of stack (level-sampled)
//   din        value to push (PC output)
//   clr_err    clears overflow/underflow; a same-cycle new error wins
//   top        registered copy of the top entry, 0 when empty
//   count      number of valid entries, 0..DEPTH
//   empty      count == 0
//   full       count == DEPTH
//   overflow   sticky: a push was rejected because the stack was full
//   underflow  sticky: a pop was rejected because the stack was empty
//
// Command semantics: there is no handshake. push and pop act as
// always-ready commands; each cycle they are high is one command, executed
// at that rising edge, with the result visible on the outputs one cycle
// later. push together with pop replaces the top entry (tail call). Rejected
// commands leave the array, count and top untouched.

module ret_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  input  logic              clr_err,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] cnt_m1;
  logic [CNT_W-1:0] cnt_m2;
  logic [AW-1:0]    idx_wr;
  logic [AW-1:0]    idx_top;
  logic [AW-1:0]    idx_below;

  logic do_replace;
  logic do_push;
  logic do_pop;
  logic ovf_evt;
  logic unf_evt;

  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);

  // Indices are only used when the matching command is legal, so each one
  // lies inside 0..DEPTH-1 and truncation to AW bits is exact.
  assign cnt_m1    = count - CNT_W'(1);
  assign cnt_m2    = count - CNT_W'(2);
  assign idx_wr    = count[AW-1:0];
  assign idx_top   = cnt_m1[AW-1:0];
  assign idx_below = cnt_m2[AW-1:0];

  always_comb begin
    do_replace = 1'b0;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (push && pop && !empty) begin
      do_replace = 1'b1;
    end else if (push) begin
      // Includes push&pop on an empty stack, which is a plain push.
      if (full) ovf_evt = 1'b1;
      else      do_push = 1'b1;
    end else if (pop) begin
      if (empty) unf_evt = 1'b1;
      else       do_pop  = 1'b1;
    end
  end

  // Array storage is deliberately not reset; only count decides validity.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (do_replace)   mem[idx_top] <= din;
      else if (do_push) mem[idx_wr]  <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      top       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (do_replace) begin
        top <= din;
      end else if (do_push) begin
        count <= count + CNT_W'(1);
        top   <= din;
      end else if (do_pop) begin
        count <= cnt_m1;
        // Popping the last entry exposes nothing, so top reads 0.
        if (count == CNT_W'(1)) top <= '0;
        else                    top <= mem[idx_below];
      end

      if (ovf_evt)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;

      if (unf_evt)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ret_stack.sv
module tb_ret_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int W      = DATA_W + CNT_W + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              clr_err = 1'b0;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;

  ret_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .top(top), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model of the stack, updated when a command is driven.
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_cnt = 0;
  logic [DATA_W-1:0] m_top = '0;
  logic              m_ovf = 1'b0;
  logic              m_unf = 1'b0;

  function automatic logic [W-1:0] pack(logic [DATA_W-1:0] t, logic [CNT_W-1:0] c,
                                        logic e, logic f, logic o, logic u);
    return {t, c, e, f, o, u};
  endfunction

  task automatic model(input logic r, input logic ps, input logic pp,
                       input logic [DATA_W-1:0] d, input logic clr);
    logic oe, ue;
    oe = 1'b0;
    ue = 1'b0;
    if (r) begin
      m_cnt = 0; m_top = '0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (ps && pp && m_cnt > 0) begin
        m_mem[m_cnt-1] = d;
        m_top = d;
      end else if (ps) begin
        if (m_cnt < DEPTH) begin
          m_mem[m_cnt] = d;
          m_cnt++;
          m_top = d;
        end else oe = 1'b1;
      end else if (pp) begin
        if (m_cnt > 1) begin
          m_cnt--;
          m_top = m_mem[m_cnt-1];
        end else if (m_cnt == 1) begin
          m_cnt = 0;
          m_top = '0;
        end else ue = 1'b1;
      end
      if (oe) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
      if (ue) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, model + enqueue, sample #1 after posedge.
  task automatic step(input string tag, input logic r, input logic ps, input logic pp,
                      input logic [DATA_W-1:0] d, input logic clr);
    logic [W-1:0] e;
    @(negedge clk);
    reset = r; push = ps; pop = pp; din = d; clr_err = clr;
    model(r, ps, pp, d, clr);
    exp_q.push_back(pack(m_top, CNT_W'(m_cnt), m_cnt == 0, m_cnt == DEPTH, m_ovf, m_unf));
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, W'(1), W'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, pack(top, count, empty, full, overflow, underflow), e);
    end
  endtask

  // Directed expectation straight from the test plan: top, count, flags.
  task automatic expect_state(input string tag, input logic [DATA_W-1:0] t,
                              input int c, input logic o, input logic u);
    chk({tag, "_plan"}, pack(top, count, empty, full, overflow, underflow),
        pack(t, CNT_W'(c), c == 0, c == DEPTH, o, u));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset then idle
    step("reset", 1, 0, 0, 8'h00, 0);
    expect_state("reset", 8'h00, 0, 0, 0);
    step("idle", 0, 0, 0, 8'h00, 0);

    // Nested calls
    step("call1", 0, 1, 0, 8'h10, 0); expect_state("call1", 8'h10, 1, 0, 0);
    step("call2", 0, 1, 0, 8'h20, 0); expect_state("call2", 8'h20, 2, 0, 0);
    step("call3", 0, 1, 0, 8'h30, 0); expect_state("call3", 8'h30, 3, 0, 0);
    step("ret1", 0, 0, 1, 8'h00, 0);  expect_state("ret1", 8'h20, 2, 0, 0);
    step("ret2", 0, 0, 1, 8'h00, 0);  expect_state("ret2", 8'h10, 1, 0, 0);
    step("ret3", 0, 0, 1, 8'h00, 0);  expect_state("ret3", 8'h00, 0, 0, 0);

    // Full stack, overflow, then pop
    for (int i = 1; i <= DEPTH; i++) step("fill", 0, 1, 0, DATA_W'(i), 0);
    expect_state("full", 8'h08, 8, 0, 0);
    step("push_full", 0, 1, 0, 8'hFF, 0);
    expect_state("push_full", 8'h08, 8, 1, 0);
    step("pop_after_full", 0, 0, 1, 8'h00, 0);
    expect_state("pop_after_full", 8'h07, 7, 1, 0);
    step("clr_ovf", 0, 0, 0, 8'h00, 1);
    expect_state("clr_ovf", 8'h07, 7, 0, 0);

    // Empty stack, underflow, clear, clear+set
    step("reset2", 1, 0, 0, 8'h00, 0);
    step("pop_empty", 0, 0, 1, 8'h00, 0);
    expect_state("pop_empty", 8'h00, 0, 0, 1);
    step("clr_unf", 0, 0, 0, 8'h00, 1);
    expect_state("clr_unf", 8'h00, 0, 0, 0);
    step("clr_and_pop", 0, 0, 1, 8'h00, 1);
    expect_state("clr_and_pop", 8'h00, 0, 0, 1);

    // Simultaneous push&pop
    step("reset3", 1, 0, 0, 8'h00, 0);
    step("p1", 0, 1, 0, 8'h10, 0);
    step("p2", 0, 1, 0, 8'h20, 0);
    step("p3", 0, 1, 0, 8'h30, 0);
    step("tail_call", 0, 1, 1, 8'h55, 0);
    expect_state("tail_call", 8'h55, 3, 0, 0);
    step("tail_ret1", 0, 0, 1, 8'h00, 0);
    expect_state("tail_ret1", 8'h20, 2, 0, 0);
    step("reset4", 1, 0, 0, 8'h00, 0);
    step("pp_empty", 0, 1, 1, 8'h44, 0);
    expect_state("pp_empty", 8'h44, 1, 0, 0);
    for (int i = 2; i <= DEPTH; i++) step("fill2", 0, 1, 0, DATA_W'(8'h40 + i), 0);
    step("pp_full", 0, 1, 1, 8'h66, 0);
    expect_state("pp_full", 8'h66, 8, 0, 0);
    step("pp_full_ret", 0, 0, 1, 8'h00, 0);
    expect_state("pp_full_ret", 8'h47, 7, 0, 0);

    // Reset mid-operation
    step("reset5", 1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) step("mid", 0, 1, 0, DATA_W'(8'hA0 + i), 0);
    expect_state("mid5", 8'hA4, 5, 0, 0);
    step("reset_push", 1, 1, 0, 8'hEE, 0);
    expect_state("reset_push", 8'h00, 0, 0, 0);
    step("pop_after_rst", 0, 0, 1, 8'h00, 0);
    expect_state("pop_after_rst", 8'h00, 0, 0, 1);

    // Random mix against the model
    for (int i = 0; i < 60; i++) begin
      step("rand", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           DATA_W'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
    end

    if (exp_q.size() != 0) chk("queue_drained", W'(exp_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety bound so the bench never hangs.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
